// File: rtl/comparator_sort_ctrl_if.sv
// Handshake and comparator bus between a word source, the sort sequencer and
// an external magnitude comparator.
interface comparator_sort_ctrl_if #(
    parameter int N = 4,
    parameter int W = 4
);
    logic           start;
    logic [N*W-1:0] data_in;
    logic           cmp_eq;
    logic           cmp_gt;
    logic           cmp_sm;
    logic [W-1:0]   cmp_a;
    logic [W-1:0]   cmp_b;
    logic           busy;
    logic           done;
    logic [N*W-1:0] data_out;
    logic [7:0]     swap_cnt;
    logic           cmp_err;

    modport master (
        output start, data_in, cmp_eq, cmp_gt, cmp_sm,
        input  cmp_a, cmp_b, busy, done, data_out, swap_cnt, cmp_err
    );

    modport slave (
        input  start, data_in, cmp_eq, cmp_gt, cmp_sm,
        output cmp_a, cmp_b, busy, done, data_out, swap_cnt, cmp_err
    );
endinterface

// File: rtl/comparator_sort_ctrl.sv
// Bubble-sort sequencer for N unsigned W-bit words using one shared external
// magnitude comparator, with start/busy/done handshake.
module comparator_sort_ctrl #(
    parameter int N = 4,
    parameter int W = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    comparator_sort_ctrl_if.slave sif
);
    localparam int            IW   = (N > 2) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    logic [N*W-1:0] r_words;
    logic [N*W-1:0] r_data_out;
    logic [IW-1:0]  r_idx;
    logic [IW-1:0]  r_pass;
    logic           r_pass_swapped;
    logic           r_busy;
    logic           r_done;
    logic           r_cmp_err;
    logic [7:0]     r_swap_cnt;

    logic [W-1:0]   w_a;
    logic [W-1:0]   w_b;
    logic           w_onehot;
    logic           w_swap;
    logic           w_end_pass;
    logic           w_finish;
    logic [N*W-1:0] w_words_nxt;

    assign w_a = r_words[int'(r_idx)*W +: W];
    assign w_b = r_words[(int'(r_idx) + 1)*W +: W];

    assign sif.cmp_a    = (r_state == S_CMP) ? w_a : {W{1'b0}};
    assign sif.cmp_b    = (r_state == S_CMP) ? w_b : {W{1'b0}};
    assign sif.busy     = r_busy;
    assign sif.done     = r_done;
    assign sif.data_out = r_data_out;
    assign sif.swap_cnt = r_swap_cnt;
    assign sif.cmp_err  = r_cmp_err;

    // Flag decode and the word vector as it stands after the current compare;
    // done loads data_out from this so the final swap is already included.
    always_comb begin
        case ({sif.cmp_eq, sif.cmp_gt, sif.cmp_sm})
            3'b100, 3'b010, 3'b001: w_onehot = 1'b1;
            default:                w_onehot = 1'b0;
        endcase
        w_swap      = (r_state == S_CMP) && w_onehot && sif.cmp_gt;
        w_words_nxt = r_words;
        if (w_swap) begin
            w_words_nxt[int'(r_idx)*W +: W]         = w_b;
            w_words_nxt[(int'(r_idx) + 1)*W +: W]   = w_a;
        end else begin
            w_words_nxt = r_words;
        end
        w_end_pass = (r_idx == LAST);
        w_finish   = w_end_pass && (!(r_pass_swapped || w_swap) || (r_pass == LAST));
    end

    // Sequencer: IDLE -> CMP (one compare per cycle) -> DONE pulse -> IDLE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_words        <= {(N*W){1'b0}};
            r_data_out     <= {(N*W){1'b0}};
            r_idx          <= {IW{1'b0}};
            r_pass         <= {IW{1'b0}};
            r_pass_swapped <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_cmp_err      <= 1'b0;
            r_swap_cnt     <= 8'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (sif.start) begin
                        r_words        <= sif.data_in;
                        r_idx          <= {IW{1'b0}};
                        r_pass         <= {IW{1'b0}};
                        r_pass_swapped <= 1'b0;
                        r_swap_cnt     <= 8'd0;
                        r_cmp_err      <= 1'b0;
                        r_busy         <= 1'b1;
                        r_state        <= S_CMP;
                    end
                end
                S_CMP: begin
                    r_words <= w_words_nxt;
                    if (w_swap) begin
                        r_pass_swapped <= 1'b1;
                        if (r_swap_cnt != 8'hFF) begin
                            r_swap_cnt <= r_swap_cnt + 8'd1;
                        end
                    end
                    if (!w_onehot) begin
                        r_cmp_err <= 1'b1;
                    end
                    if (!w_end_pass) begin
                        r_idx <= r_idx + 1'b1;
                    end else if (w_finish) begin
                        r_state    <= S_DONE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_data_out <= w_words_nxt;
                    end else begin
                        r_pass         <= r_pass + 1'b1;
                        r_idx          <= {IW{1'b0}};
                        r_pass_swapped <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
